// File: rtl/dht_pkg.sv
// Shared types and cycle-count helpers for the DHT11 single-wire reader.
// All timing constants are converted to clock cycles at elaboration time.
package dht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } dht_state_t;

    localparam int FRAME_BITS = 40;
    localparam int CNT_W      = 27;

    function automatic logic [CNT_W-1:0] us_cycles(input int clk_hz, input int us);
        return CNT_W'(longint'(clk_hz / 1_000_000) * longint'(us));
    endfunction

    function automatic logic [CNT_W-1:0] ms_cycles(input int clk_hz, input int ms);
        return us_cycles(clk_hz, ms * 1000);
    endfunction

endpackage

// File: rtl/dht_sync.sv
// Two-flop synchroniser for the raw data line plus a delayed copy for edge detect.
// Flops reset high to match the idle (pulled-up) line and avoid a spurious fall.
module dht_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign lvl  = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 controller: periodic start pulse, 40-bit frame capture, checksum check.
// One shared cycle counter times every state and clears on each state change.
module dht11_reader
    import dht_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int SAMPLE_MS     = 2000,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic [15:0] temp_out,
    output logic [15:0] hum_out,
    output logic        data_valid,
    output logic        chk_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] IDLE_TC   = ms_cycles(CLK_HZ, SAMPLE_MS) - CNT_W'(1);
    localparam logic [CNT_W-1:0] START_TC  = us_cycles(CLK_HZ, START_LOW_US) - CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH    = us_cycles(CLK_HZ, BIT_THRESH_US);
    localparam logic [CNT_W-1:0] TMO_TC    = us_cycles(CLK_HZ, TIMEOUT_US) - CNT_W'(1);
    localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);

    dht_state_t state;
    dht_state_t state_next;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      hi_cycles;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic [7:0]            chk_sum;

    logic line_lvl;
    logic line_rise;
    logic line_fall;
    logic phase_tmo;
    logic shift_en;
    logic do_valid;
    logic do_chk;
    logic do_tmo;

    dht_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (dht_in),
        .lvl   (line_lvl),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    // The counter is cleared on entry to BIT_HIGH, so the line has been high cnt+1 cycles.
    assign hi_cycles = cnt + CNT_W'(1);
    assign phase_tmo = (cnt == TMO_TC);
    assign chk_sum   = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        do_valid   = 1'b0;
        do_chk     = 1'b0;
        do_tmo     = 1'b0;
        case (state)
            IDLE: begin
                // Never pull the line while the sensor is still holding it low.
                if (cnt >= IDLE_TC && line_lvl) state_next = START_LOW;
            end
            START_LOW: begin
                if (cnt == START_TC) state_next = RELEASE;
            end
            RELEASE: begin
                if (line_fall) state_next = RESP_LOW;
                else if (phase_tmo) begin
                    state_next = IDLE;
                    do_tmo     = 1'b1;
                end
            end
            RESP_LOW: begin
                if (line_rise) state_next = RESP_HIGH;
                else if (phase_tmo) begin
                    state_next = IDLE;
                    do_tmo     = 1'b1;
                end
            end
            RESP_HIGH: begin
                if (line_fall) state_next = BIT_LOW;
                else if (phase_tmo) begin
                    state_next = IDLE;
                    do_tmo     = 1'b1;
                end
            end
            BIT_LOW: begin
                if (line_rise) state_next = BIT_HIGH;
                else if (phase_tmo) begin
                    state_next = IDLE;
                    do_tmo     = 1'b1;
                end
            end
            BIT_HIGH: begin
                if (line_fall) begin
                    shift_en   = 1'b1;
                    state_next = (bit_cnt == LAST_BIT) ? CHECK : BIT_LOW;
                end else if (phase_tmo) begin
                    state_next = IDLE;
                    do_tmo     = 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (chk_sum == frame[7:0]) do_valid = 1'b1;
                else                       do_chk   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            frame   <= '0;
        end else begin
            if (state == RESP_HIGH) bit_cnt <= '0;
            else if (shift_en)      bit_cnt <= bit_cnt + 6'd1;
            if (shift_en) frame <= {frame[FRAME_BITS-2:0], (hi_cycles > THRESH)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hum_out     <= '0;
            temp_out    <= '0;
            data_valid  <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            data_valid  <= do_valid;
            chk_err     <= do_chk;
            timeout_err <= do_tmo;
            if (do_valid) begin
                hum_out  <= {8'd0, frame[39:32]};
                temp_out <= {8'd0, frame[23:16]};
            end
        end
    end

    assign dht_oe = (state == START_LOW);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench: a DHT11 line model drives randomized frames; expected events
// go into a scoreboard queue that a negedge monitor drains whenever the DUT pulses.
module tb_dht11_reader;

    localparam int CLK_HZ        = 1_000_000;
    localparam int SAMPLE_MS     = 1;
    localparam int START_LOW_US  = 100;
    localparam int BIT_THRESH_US = 40;
    localparam int TIMEOUT_US    = 200;

    localparam int CYC = CLK_HZ / 1_000_000;
    localparam int P   = SAMPLE_MS * 1000 * CYC;
    localparam int S   = START_LOW_US * CYC;
    localparam int THR = BIT_THRESH_US * CYC;
    localparam int TMO = TIMEOUT_US * CYC;

    localparam int K_VALID = 0;
    localparam int K_CHK   = 1;
    localparam int K_TMO   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sens = 1'b1;
    logic        dht_in;
    logic        dht_oe;
    logic [15:0] temp_out;
    logic [15:0] hum_out;
    logic        data_valid;
    logic        chk_err;
    logic        timeout_err;
    logic        busy;

    assign dht_in = dht_oe ? 1'b0 : sens;

    always #5 clk = ~clk;

    dht11_reader #(
        .CLK_HZ        (CLK_HZ),
        .SAMPLE_MS     (SAMPLE_MS),
        .START_LOW_US  (START_LOW_US),
        .BIT_THRESH_US (BIT_THRESH_US),
        .TIMEOUT_US    (TIMEOUT_US)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dht_in      (dht_in),
        .dht_oe      (dht_oe),
        .temp_out    (temp_out),
        .hum_out     (hum_out),
        .data_valid  (data_valid),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    typedef struct {
        int          kind;
        logic [15:0] hum;
        logic [15:0] temp;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] good_hum = 8'd0;
    logic [7:0] good_temp = 8'd0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (data_valid || chk_err || timeout_err)) begin
            int   got_kind;
            exp_t e;
            got_kind = data_valid ? K_VALID : (chk_err ? K_CHK : K_TMO);
            check("pulse_onehot", int'(data_valid) + int'(chk_err) + int'(timeout_err), 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d expected no event", got_kind);
            end else begin
                e = sb.pop_front();
                check("event_kind", got_kind, e.kind);
                check("hum_out", hum_out, e.hum);
                check("temp_out", temp_out, e.temp);
                check("busy_after_frame", busy, 0);
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        sens = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_oe_rise(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (dht_oe) break;
            if (n >= 3 * P + S) begin
                checks++;
                errors++;
                $display("FAIL start_wait: got no start pulse after %0d cycles expected %0d", n, P);
                break;
            end
        end
    endtask

    function automatic logic [39:0] mk(input logic [7:0] h, input logic [7:0] hd,
                                       input logic [7:0] t, input logic [7:0] td,
                                       input logic [7:0] c);
        return {h, hd, t, td, c};
    endfunction

    // mode 0: full frame, 1: no sensor response, 2: bit 'special' stuck high,
    // 3: reset asserted during bit 'special'. wmode 1 uses threshold / threshold+1 widths.
    task automatic do_frame(input logic [39:0] bits, input int wmode, input int mode,
                            input int special, output int wait_n);
        int          w[40];
        int          wd;
        int          k;
        int          oe_bad;
        int          stuck;
        logic [39:0] dec;
        exp_t        e;
        logic [7:0]  sum;

        wait_oe_rise(wait_n);
        wd = 0;
        forever begin
            @(negedge clk);
            wd++;
            if (!dht_oe || wd > 4 * S) break;
        end
        check("start_low_width", wd, S);

        stuck = 0;
        for (int i = 0; i < 40; i++) begin
            if (wmode == 1) w[i] = bits[39-i] ? THR + 1 : THR;
            else            w[i] = bits[39-i] ? int'($urandom_range(80, 60)) : int'($urandom_range(35, 20));
            if (mode == 2 && i == special) w[i] = TMO + 100;
            if (w[i] > TMO) stuck = 1;
            dec[39-i] = (w[i] > THR);
        end

        e.hum = {8'd0, good_hum};
        e.temp = {8'd0, good_temp};
        if (mode == 1 || (mode == 2 && stuck != 0)) begin
            e.kind = K_TMO;
            sb.push_back(e);
        end else if (mode == 0) begin
            sum = 8'((int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8])) % 256);
            if (sum == dec[7:0]) begin
                good_hum  = dec[39:32];
                good_temp = dec[23:16];
                e.kind = K_VALID;
                e.hum  = {8'd0, good_hum};
                e.temp = {8'd0, good_temp};
            end else begin
                e.kind = K_CHK;
            end
            sb.push_back(e);
        end

        if (mode == 1) begin
            k = 0;
            oe_bad = 0;
            sens = 1'b1;
            forever begin
                @(negedge clk);
                k++;
                if (dht_oe) oe_bad++;
                if (timeout_err || k > 4 * TMO) break;
            end
            check("timeout_latency", k, TMO);
            check("oe_released_during_wait", oe_bad, 0);
            return;
        end

        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            hold(1'b0, 50);
            if (mode == 3 && i == special) begin
                hold(1'b1, 10);
                #3 reset = 1'b1;
                #1;
                check("rst_dht_oe", dht_oe, 0);
                check("rst_hum_out", hum_out, 0);
                check("rst_temp_out", temp_out, 0);
                check("rst_busy", busy, 0);
                check("rst_data_valid", data_valid, 0);
                good_hum  = 8'd0;
                good_temp = 8'd0;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                sens = 1'b1;
                return;
            end
            hold(1'b1, w[i]);
            if (w[i] > TMO) begin
                hold(1'b0, 50);
                sens = 1'b1;
                return;
            end
        end
        hold(1'b0, 50);
        sens = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] h, hd, t, td, c;

        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_dht_oe", dht_oe, 0);
        check("reset_temp_out", temp_out, 0);
        check("reset_hum_out", hum_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_chk_err", chk_err, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;

        do_frame(mk(8'd65, 8'd0, 8'd22, 8'd0, 8'd88), 0, 0, 0, n);
        check("first_start_delay", n, P);
        do_frame(mk(8'd65, 8'd0, 8'd22, 8'd0, 8'd87), 0, 0, 0, n);
        do_frame(mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 0, 1, 0, n);
        do_frame(mk(8'd40, 8'd3, 8'd25, 8'd7, 8'd75), 1, 0, 0, n);
        check("start_after_timeout", n, P);
        do_frame(mk(8'd55, 8'd1, 8'd30, 8'd2, 8'd88), 0, 2, 10, n);
        do_frame(mk(8'd70, 8'd0, 8'd19, 8'd0, 8'd89), 0, 3, 20, n);
        do_frame(mk(8'd50, 8'd0, 8'd21, 8'd5, 8'd76), 0, 0, 0, n);
        check("start_after_reset", n, P);

        for (int r = 0; r < 3; r++) begin
            h  = 8'($urandom_range(99, 0));
            hd = 8'($urandom_range(9, 0));
            t  = 8'($urandom_range(50, 0));
            td = 8'($urandom_range(9, 0));
            c  = h + hd + t + td;
            if (r == 1) c = c + 8'd1;
            do_frame(mk(h, hd, t, td, c), 0, 0, 0, n);
        end

        repeat (P / 2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
